// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control
// Description : Multi-cycle control FSM for an RV32I subset (R-type, I-arith,
//               load, store, branch). Steps each instruction through
//               FETCH/DECODE/EXECUTE/MEM/WB states, drives Moore-style
//               datapath strobes, waits on a memory-ready handshake, traps
//               on illegal opcodes or memory timeout and counts retirements.
// Optional    : CTRL_JAL_EN - adds a JAL state for opcode 1101111; when
//               undefined that opcode traps as illegal.
// Ports       : i_clk, i_reset (async, active-high), i_opcode[6:0],
//               i_mem_ready -> o_branch, o_pc_write, o_ior_d, o_mem_read,
//               o_mem_write, o_ir_write, o_mem_to_reg, o_reg_write,
//               o_alu_src_a, o_alu_src_b[1:0], o_alu_op[1:0],
//               o_pc_source[1:0], o_illegal, o_mem_fault, o_state[3:0],
//               o_retire_count[RETIRE_W-1:0]
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control #(
  parameter int RETIRE_W    = 32,
  parameter int MEM_TIMEOUT = 16,
  parameter int TRAP_HALT   = 1
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [6:0]          i_opcode,
  input  logic                i_mem_ready,
  output logic                o_branch,
  output logic                o_pc_write,
  output logic                o_ior_d,
  output logic                o_mem_read,
  output logic                o_mem_write,
  output logic                o_ir_write,
  output logic                o_mem_to_reg,
  output logic                o_reg_write,
  output logic                o_alu_src_a,
  output logic [1:0]          o_alu_src_b,
  output logic [1:0]          o_alu_op,
  output logic [1:0]          o_pc_source,
  output logic                o_illegal,
  output logic                o_mem_fault,
  output logic [3:0]          o_state,
  output logic [RETIRE_W-1:0] o_retire_count
);

  localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] c_TIMEOUT = WAIT_W'(MEM_TIMEOUT);

  localparam logic [3:0] c_FETCH  = 4'd0;
  localparam logic [3:0] c_DECODE = 4'd1;
  localparam logic [3:0] c_MEMADR = 4'd2;
  localparam logic [3:0] c_MEMRD  = 4'd3;
  localparam logic [3:0] c_MEMWB  = 4'd4;
  localparam logic [3:0] c_MEMWR  = 4'd5;
  localparam logic [3:0] c_EXEC_R = 4'd6;
  localparam logic [3:0] c_EXEC_I = 4'd7;
  localparam logic [3:0] c_ALUWB  = 4'd8;
  localparam logic [3:0] c_BRANCH = 4'd9;
  localparam logic [3:0] c_TRAP   = 4'd10;
`ifdef CTRL_JAL_EN
  localparam logic [3:0] c_JAL    = 4'd11;
  localparam logic [6:0] c_OP_JAL = 7'b1101111;
`endif

  localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
  localparam logic [6:0] c_OP_STORE = 7'b0100011;
  localparam logic [6:0] c_OP_R     = 7'b0110011;
  localparam logic [6:0] c_OP_I     = 7'b0010011;
  localparam logic [6:0] c_OP_BR    = 7'b1100011;

  logic [3:0]          r_state;
  logic [3:0]          w_next;
  logic [WAIT_W-1:0]   r_wait;
  logic [RETIRE_W-1:0] r_retire;
  logic                r_illegal;
  logic                r_mem_fault;
  logic                w_retire;
  logic                w_set_ill;
  logic                w_set_flt;
  logic                w_timeout;
  logic                w_waiting;

  // Timeout fires only while still waiting at the limit; a ready in that
  // same cycle takes priority in the next-state logic below.
  assign w_timeout = (MEM_TIMEOUT != 0) && (r_wait == c_TIMEOUT) && !i_mem_ready;
  assign w_waiting = (r_state == c_FETCH) || (r_state == c_MEMRD) || (r_state == c_MEMWR);

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= c_FETCH;
    else         r_state <= w_next;
  end

  // Wait counter, retirement counter and trap cause
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wait      <= '0;
      r_retire    <= '0;
      r_illegal   <= 1'b0;
      r_mem_fault <= 1'b0;
    end else begin
      // Any state change counts as a fresh entry into a wait state.
      if ((w_next != r_state) || i_mem_ready) r_wait <= '0;
      else if (w_waiting)                     r_wait <= r_wait + 1'b1;

      if (w_retire) r_retire <= r_retire + 1'b1;

      if ((w_next == c_TRAP) && (r_state != c_TRAP)) begin
        r_illegal   <= w_set_ill;
        r_mem_fault <= w_set_flt;
      end else if ((r_state == c_TRAP) && (w_next != c_TRAP)) begin
        r_illegal   <= 1'b0;
        r_mem_fault <= 1'b0;
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_next    = r_state;
    w_retire  = 1'b0;
    w_set_ill = 1'b0;
    w_set_flt = 1'b0;
    case (r_state)
      c_FETCH: begin
        if (i_mem_ready)    w_next = c_DECODE;
        else if (w_timeout) begin w_next = c_TRAP; w_set_flt = 1'b1; end
      end
      c_DECODE: begin
        case (i_opcode)
          c_OP_LOAD, c_OP_STORE: w_next = c_MEMADR;
          c_OP_R:                w_next = c_EXEC_R;
          c_OP_I:                w_next = c_EXEC_I;
          c_OP_BR:               w_next = c_BRANCH;
`ifdef CTRL_JAL_EN
          c_OP_JAL:              w_next = c_JAL;
`endif
          default: begin w_next = c_TRAP; w_set_ill = 1'b1; end
        endcase
      end
      // Only loads and stores reach MEMADR; bit 5 tells them apart.
      c_MEMADR: w_next = i_opcode[5] ? c_MEMWR : c_MEMRD;
      c_MEMRD: begin
        if (i_mem_ready)    w_next = c_MEMWB;
        else if (w_timeout) begin w_next = c_TRAP; w_set_flt = 1'b1; end
      end
      c_MEMWB:  begin w_next = c_FETCH; w_retire = 1'b1; end
      c_MEMWR: begin
        if (i_mem_ready)    begin w_next = c_FETCH; w_retire = 1'b1; end
        else if (w_timeout) begin w_next = c_TRAP; w_set_flt = 1'b1; end
      end
      c_EXEC_R: w_next = c_ALUWB;
      c_EXEC_I: w_next = c_ALUWB;
      c_ALUWB:  begin w_next = c_FETCH; w_retire = 1'b1; end
      c_BRANCH: begin w_next = c_FETCH; w_retire = 1'b1; end
      c_TRAP:   if (TRAP_HALT == 0) w_next = c_FETCH;
`ifdef CTRL_JAL_EN
      c_JAL:    begin w_next = c_FETCH; w_retire = 1'b1; end
`endif
      default:  w_next = c_FETCH;
    endcase
  end

  // Moore outputs; all forced low while reset is asserted
  always_comb begin
    o_branch     = 1'b0;
    o_pc_write   = 1'b0;
    o_ior_d      = 1'b0;
    o_mem_read   = 1'b0;
    o_mem_write  = 1'b0;
    o_ir_write   = 1'b0;
    o_mem_to_reg = 1'b0;
    o_reg_write  = 1'b0;
    o_alu_src_a  = 1'b0;
    o_alu_src_b  = 2'b00;
    o_alu_op     = 2'b00;
    o_pc_source  = 2'b00;
    o_illegal    = 1'b0;
    o_mem_fault  = 1'b0;
    if (!i_reset) begin
      case (r_state)
        c_FETCH: begin
          o_mem_read  = 1'b1;
          o_alu_src_b = 2'b01;
          o_ir_write  = i_mem_ready;
          o_pc_write  = i_mem_ready;
        end
        c_DECODE: o_alu_src_b = 2'b10;
        c_MEMADR: begin o_alu_src_a = 1'b1; o_alu_src_b = 2'b10; end
        c_MEMRD:  begin o_mem_read = 1'b1; o_ior_d = 1'b1; end
        c_MEMWB:  begin o_reg_write = 1'b1; o_mem_to_reg = 1'b1; end
        c_MEMWR:  begin o_mem_write = 1'b1; o_ior_d = 1'b1; end
        c_EXEC_R: begin o_alu_src_a = 1'b1; o_alu_op = 2'b10; end
        c_EXEC_I: begin o_alu_src_a = 1'b1; o_alu_src_b = 2'b10; o_alu_op = 2'b11; end
        c_ALUWB:  o_reg_write = 1'b1;
        c_BRANCH: begin
          o_alu_src_a = 1'b1;
          o_alu_op    = 2'b01;
          o_branch    = 1'b1;
          o_pc_source = 2'b01;
        end
        c_TRAP: begin
          o_illegal   = r_illegal;
          o_mem_fault = r_mem_fault;
        end
`ifdef CTRL_JAL_EN
        c_JAL: begin
          o_reg_write = 1'b1;
          o_alu_src_b = 2'b01;
          o_pc_write  = 1'b1;
          o_pc_source = 2'b10;
        end
`endif
        default: ;
      endcase
    end
  end

  assign o_state        = i_reset ? 4'd0 : r_state;
  assign o_retire_count = r_retire;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control
// Description : Randomized self-checking bench for multicycle_control. Each
//               instruction is expanded by a reference model into the
//               expected per-cycle state sequence and memory-ready pattern;
//               strobes and the retire count are predicted from the state
//               table. Honors CTRL_JAL_EN the same way the design does.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

  localparam int TO = 4;
  localparam int RW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic        mem_ready;
  logic        o_branch, o_pc_write, o_ior_d, o_mem_read, o_mem_write;
  logic        o_ir_write, o_mem_to_reg, o_reg_write, o_alu_src_a;
  logic [1:0]  o_alu_src_b, o_alu_op, o_pc_source;
  logic        o_illegal, o_mem_fault;
  logic [3:0]  o_state;
  logic [RW-1:0] o_retire_count;

  multicycle_control #(.RETIRE_W(RW), .MEM_TIMEOUT(TO), .TRAP_HALT(1)) u_dut (
    .i_clk(clk), .i_reset(rst), .i_opcode(opcode), .i_mem_ready(mem_ready),
    .o_branch(o_branch), .o_pc_write(o_pc_write), .o_ior_d(o_ior_d),
    .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_ir_write(o_ir_write),
    .o_mem_to_reg(o_mem_to_reg), .o_reg_write(o_reg_write),
    .o_alu_src_a(o_alu_src_a), .o_alu_src_b(o_alu_src_b), .o_alu_op(o_alu_op),
    .o_pc_source(o_pc_source), .o_illegal(o_illegal), .o_mem_fault(o_mem_fault),
    .o_state(o_state), .o_retire_count(o_retire_count)
  );

  always #5 clk = ~clk;

  logic [16:0] w_dut;
  assign w_dut = {o_branch, o_pc_write, o_ior_d, o_mem_read, o_mem_write,
                  o_ir_write, o_mem_to_reg, o_reg_write, o_alu_src_a,
                  o_alu_src_b, o_alu_op, o_pc_source, o_illegal, o_mem_fault};

  int n_cmp = 0;
  int n_err = 0;

  // Model state
  int st_q[$];
  bit rdy_q[$];
  bit m_ill, m_flt, m_trapped;
  int m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Strobe table per state (numbering as architected)
  function automatic logic [16:0] exp_out(input int st, input bit rdy, input bit ill, input bit flt);
    logic br, pcw, iord, mr, mw, irw, m2r, rw, asa, il, mf;
    logic [1:0] asb, aop, pcs;
    {br, pcw, iord, mr, mw, irw, m2r, rw, asa, il, mf} = '0;
    asb = 2'd0; aop = 2'd0; pcs = 2'd0;
    case (st)
      0:  begin mr = 1; asb = 2'd1; irw = rdy; pcw = rdy; end
      1:  asb = 2'd2;
      2:  begin asa = 1; asb = 2'd2; end
      3:  begin mr = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mw = 1; iord = 1; end
      6:  begin asa = 1; aop = 2'd2; end
      7:  begin asa = 1; asb = 2'd2; aop = 2'd3; end
      8:  rw = 1;
      9:  begin asa = 1; aop = 2'd1; br = 1; pcs = 2'd1; end
      10: begin il = ill; mf = flt; end
      11: begin rw = 1; asb = 2'd1; pcw = 1; pcs = 2'd2; end
      default: ;
    endcase
    return {br, pcw, iord, mr, mw, irw, m2r, rw, asa, asb, aop, pcs, il, mf};
  endfunction

  task automatic push(input int s, input bit r);
    st_q.push_back(s);
    rdy_q.push_back(r);
  endtask

  // A memory wait of d low cycles; beyond TO+1 low cycles the access times out.
  task automatic add_wait(input int s, input int d, output bit trapped);
    if (d <= TO) begin
      for (int i = 0; i < d; i++) push(s, 1'b0);
      push(s, 1'b1);
      trapped = 1'b0;
    end else begin
      for (int i = 0; i <= TO; i++) push(s, 1'b0);
      trapped = 1'b1;
    end
  endtask

  task automatic build(input logic [6:0] opc, input int fd, input int md, input int trap_cycles);
    bit t;
    st_q.delete(); rdy_q.delete();
    m_ill = 0; m_flt = 0; t = 0;
    opcode = opc;
    add_wait(0, fd, t);
    if (t) m_flt = 1;
    else begin
      push(1, 1'($urandom));
      case (opc)
        7'b0000011: begin push(2, 1'($urandom)); add_wait(3, md, t); if (t) m_flt = 1; else push(4, 1'($urandom)); end
        7'b0100011: begin push(2, 1'($urandom)); add_wait(5, md, t); if (t) m_flt = 1; end
        7'b0110011: begin push(6, 1'($urandom)); push(8, 1'($urandom)); end
        7'b0010011: begin push(7, 1'($urandom)); push(8, 1'($urandom)); end
        7'b1100011: push(9, 1'($urandom));
`ifdef CTRL_JAL_EN
        7'b1101111: push(11, 1'($urandom));
`endif
        default: begin t = 1; m_ill = 1; end
      endcase
    end
    m_trapped = t;
    if (t) for (int i = 0; i < trap_cycles; i++) push(10, 1'($urandom));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'b1;
    #2;
    check("rst_state", 32'(o_state), 32'd0);
    check("rst_outs", 32'(w_dut), 32'd0);
    check("rst_count", 32'(o_retire_count), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_cnt = 0;
  endtask

  task automatic run(input int abort_idx);
    for (int i = 0; i < st_q.size(); i++) begin
      mem_ready = rdy_q[i];
      @(negedge clk);
      check("state", 32'(o_state), 32'(st_q[i]));
      check("outs", 32'(w_dut), 32'(exp_out(st_q[i], rdy_q[i], m_ill, m_flt)));
      check("count", 32'(o_retire_count), 32'(m_cnt));
      if (i == abort_idx) begin
        do_reset();
        return;
      end
      @(posedge clk); #1;
    end
    if (m_trapped) do_reset();
    else m_cnt = (m_cnt + 1) % (1 << RW);
  endtask

  function automatic logic [6:0] rand_op();
    case ($urandom % 8)
      0, 7: return 7'b0110011;
      1:    return 7'b0010011;
      2:    return 7'b0000011;
      3:    return 7'b0100011;
      4:    return 7'b1100011;
      5:    return 7'b1101111;
      default: return 7'($urandom);
    endcase
  endfunction

  function automatic int rand_delay();
    if ($urandom % 10 == 0) return TO + 1 + int'($urandom % 3);
    return int'($urandom % 3);
  endfunction

  initial begin
    rst = 1'b1;
    mem_ready = 1'b1;
    opcode = 7'b0110011;
    m_cnt = 0;
    #3;
    do_reset();

    // R-type, immediate handshake
    build(7'b0110011, 0, 0, 0); run(-1);
    // Load with memory held off three cycles
    build(7'b0000011, 0, 3, 0); run(-1);
    // Illegal opcode, halt for 20 cycles
    build(7'b1110011, 0, 0, 20); run(-1);
    // Store with memory stuck low -> timeout trap
    build(7'b0100011, 0, 99, 3); run(-1);
    // Fill to 15 retirements, then one more wraps to 0
    for (int k = 0; k < 16; k++) begin build(7'b1100011, 0, 0, 0); run(-1); end
    check("wrap", 32'(o_retire_count), 32'd0);
    // Reset during EXEC_R
    build(7'b0110011, 0, 0, 0); run(2);

    for (int k = 0; k < 300; k++) begin
      build(rand_op(), rand_delay(), rand_delay(), 1 + int'($urandom % 3));
      run(($urandom % 15 == 0) ? int'($urandom % st_q.size()) : -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Parametrised multi-cycle successor to the single-cycle main decoder for the RV32I subset: R-type, I-arith, load, store and branch.
- Sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WB states and drives Moore-style datapath strobes per state.
- Waits on a memory-ready handshake, traps on illegal opcodes or memory timeout, and counts retired instructions.
- Sits between the instruction register (IR) opcode field and the shared-memory multi-cycle datapath.

Parameters:
- RETIRE_W, 32, width of the retired-instruction counter; wraps modulo 2^RETIRE_W.
- MEM_TIMEOUT, 16, maximum cycles to wait for mem_ready in any memory state; 0 disables the timeout.
- TRAP_HALT, 1, 1: TRAP holds until reset; 0: TRAP lasts one cycle, then goes to FETCH.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- opcode  in  7  IR[6:0], stable from DECODE until instruction end.
- mem_ready  in  1  memory has completed the current read/write this cycle.
- branch  out  1  conditional PC write (PC is written if ALU zero).
- pc_write  out  1  unconditional PC write.
- ior_d  out  1  memory address select: 0=PC, 1=ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  IR load.
- mem_to_reg  out  1  write-back select: 1=MDR, 0=ALUOut.
- reg_write  out  1  register-file write.
- alu_src_a  out  1  ALU A select: 0=PC, 1=rs1.
- alu_src_b  out  2  ALU B select: 00=rs2, 01=const 4, 10=imm.
- alu_op  out  2  00=add, 01=branch compare, 10=R-funct, 11=I-funct.
- pc_source  out  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target.
- illegal  out  1  high while in TRAP due to a bad opcode.
- mem_fault  out  1  high while in TRAP due to memory timeout.
- state  out  4  current state encoding, for debug.
- retire_count  out  RETIRE_W  count of retired instructions.

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC_R=6, EXEC_I=7, ALUWB=8, BRANCH=9, TRAP=10, JAL=11.
- Reset: state=FETCH, retire_count=0, wait counter=0, trap cause cleared.
- While reset is high, every strobe and ALU select output is forced to 0 combinationally; state reads 0.
- Reset mid-instruction aborts it immediately; the aborted instruction is not counted.
- Outputs not listed for a state are 0.
- FETCH:
  - mem_read=1, ior_d=0, alu_src_a=0, alu_src_b=01, alu_op=00.
  - ir_write=pc_write=mem_ready.
  - Stay while !mem_ready; go to DECODE on mem_ready.
- DECODE:
  - alu_src_a=0, alu_src_b=10, alu_op=00 (precomputes branch target into ALUOut).
  - Next state: 0000011 or 0100011 -> MEMADR; 0110011 -> EXEC_R; 0010011 -> EXEC_I; 1100011 -> BRANCH; any other opcode -> TRAP with illegal set.
- MEMADR:
  - alu_src_a=1, alu_src_b=10, alu_op=00.
  - Load -> MEMRD; store -> MEMWR.
- MEMRD: mem_read=1, ior_d=1; wait for mem_ready -> MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1 -> FETCH; retires.
- MEMWR: mem_write=1, ior_d=1; wait for mem_ready -> FETCH; retires on the mem_ready cycle.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10 -> ALUWB.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=11 -> ALUWB.
- ALUWB: reg_write=1, mem_to_reg=0 -> FETCH; retires.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, branch=1, pc_source=01 -> FETCH; retires whether taken or not.
- Wait counter (applies in FETCH, MEMRD, MEMWR):
  - Cleared on entry to any of these states and on mem_ready.
  - Increments each cycle spent waiting.
  - If MEM_TIMEOUT!=0 and the counter reaches MEM_TIMEOUT with mem_ready still low: go to TRAP, set mem_fault, issue no write strobes.
  - mem_ready in the same cycle the count reaches MEM_TIMEOUT wins: the access completes normally.
- TRAP:
  - All strobes 0; illegal or mem_fault held high according to cause.
  - TRAP_HALT=1: stay until reset.
  - TRAP_HALT=0: go to FETCH after one cycle and clear the cause.
- retire_count: +1 on each retiring transition, wraps from all-ones to 0. Latency: R/I = 4 cycles, load = 5, store = 4, branch = 3, each with mem_ready immediate.

Optional Feature:
- Macro: CTRL_JAL_EN.
- Defined: opcode 1101111 in DECODE -> JAL.
  - JAL: reg_write=1, mem_to_reg=0, alu_src_a=0, alu_src_b=01, alu_op=00 (writes PC+4 to rd), pc_write=1, pc_source=10.
  - JAL then goes to FETCH and retires.
- Undefined: the JAL state is absent and 1101111 traps as illegal.

Test Plan:
- Reset held, mem_ready=1 -> all strobes 0, state=0; after release, FETCH asserts mem_read=1, ir_write=1, pc_write=1.
- opcode=0110011, mem_ready=1 -> states 0,1,6,8,0; reg_write only in ALUWB; retire_count 0->1.
- opcode=0000011, mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles; MEMWB asserts reg_write=1, mem_to_reg=1; count +1.
- opcode=1110011 -> TRAP after DECODE; illegal=1; with TRAP_HALT=1, state stays 10 for 20 cycles; no reg_write or mem_write.
- MEM_TIMEOUT=4, mem_ready stuck 0 in MEMWR -> TRAP after 4 wait cycles, mem_fault=1; mem_write is never high in TRAP.
- retire_count preset near wrap (RETIRE_W=4, 15 retired) -> next retire gives 0; reset mid-EXEC_R -> state=0, count=0.
